// File: rtl/x2050_mvr_feed.sv
// x2050_mvr_feed: mover input stage for the 2050 datapath.
// Holds LB/MB byte counters and the SS-operation length counter in two banks
// (CPU and I/O) so an I/O break-in leaves an interrupted CPU SS operation intact.
// Selects U from the L register and V from the R register for the mover.
//
// Ports:
//   i_clk, i_reset        clock, asynchronous active-low reset
//   i_ros_advance         microword advance strobe; state moves only when high
//   i_io_mode             bank select: 0 = CPU, 1 = I/O
//   i_l_reg, i_r_reg      L and R registers (byte 0 = bits 31:24)
//   i_lb_ctl/i_lb_val     LB function (hold/load/inc/dec) and load value
//   i_mb_ctl/i_mb_val     MB function and load value
//   i_len_ctl/i_len_val   LEN function (hold/load/dec/hold) and load value
//   o_u, o_v              selected L / R bytes (combinational)
//   o_lb, o_mb            active bank counters (combinational)
//   o_lb_wrap, o_mb_wrap  last advance wrapped LB / MB (registered)
//   o_len_zero            active bank LEN == 0 (combinational)
//   o_len_borrow          last advance borrowed LEN 0 -> 0xFF (registered)
module x2050_mvr_feed (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_ros_advance,
  input  logic        i_io_mode,
  input  logic [31:0] i_l_reg,
  input  logic [31:0] i_r_reg,
  input  logic [1:0]  i_lb_ctl,
  input  logic [1:0]  i_lb_val,
  input  logic [1:0]  i_mb_ctl,
  input  logic [1:0]  i_mb_val,
  input  logic [1:0]  i_len_ctl,
  input  logic [7:0]  i_len_val,
  output logic [7:0]  o_u,
  output logic [7:0]  o_v,
  output logic [1:0]  o_lb,
  output logic [1:0]  o_mb,
  output logic        o_lb_wrap,
  output logic        o_mb_wrap,
  output logic        o_len_zero,
  output logic        o_len_borrow
);

  localparam int unsigned REG_W  = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned LEN_W  = 8;

  localparam logic [1:0] CTL_HOLD = 2'd0;
  localparam logic [1:0] CTL_LOAD = 2'd1;
  localparam logic [1:0] CTL_INC  = 2'd2;
  localparam logic [1:0] CTL_DEC  = 2'd3;

  typedef struct packed {
    logic [IDX_W-1:0] lb;
    logic [IDX_W-1:0] mb;
    logic [LEN_W-1:0] len;
  } bank_t;

  bank_t bank_q [2];
  bank_t act;
  bank_t upd;
  logic  lb_wrap_d;
  logic  mb_wrap_d;
  logic  len_borrow_d;
  logic  lb_wrap_q;
  logic  mb_wrap_q;
  logic  len_borrow_q;

  // Byte 0 is the most significant byte of the register.
  function automatic logic [BYTE_W-1:0] sel_byte(input logic [REG_W-1:0] r,
                                                 input logic [IDX_W-1:0] idx);
    logic [BYTE_W-1:0] b;
    case (idx)
      2'd0:    b = r[31:24];
      2'd1:    b = r[23:16];
      2'd2:    b = r[15:8];
      default: b = r[7:0];
    endcase
    return b;
  endfunction

  assign act = bank_q[i_io_mode];

  // Next value of the active bank and the wrap/borrow indications of this advance.
  always_comb begin
    upd          = act;
    lb_wrap_d    = 1'b0;
    mb_wrap_d    = 1'b0;
    len_borrow_d = 1'b0;

    case (i_lb_ctl)
      CTL_LOAD: upd.lb = i_lb_val;
      CTL_INC: begin
        upd.lb    = act.lb + IDX_W'(1);
        lb_wrap_d = (act.lb == IDX_W'(3));
      end
      CTL_DEC: begin
        upd.lb    = act.lb - IDX_W'(1);
        lb_wrap_d = (act.lb == IDX_W'(0));
      end
      default: ;
    endcase

    case (i_mb_ctl)
      CTL_LOAD: upd.mb = i_mb_val;
      CTL_INC: begin
        upd.mb    = act.mb + IDX_W'(1);
        mb_wrap_d = (act.mb == IDX_W'(3));
      end
      CTL_DEC: begin
        upd.mb    = act.mb - IDX_W'(1);
        mb_wrap_d = (act.mb == IDX_W'(0));
      end
      default: ;
    endcase

    // Code 3 on the length control is reserved and holds, same as code 0.
    case (i_len_ctl)
      CTL_LOAD: upd.len = i_len_val;
      CTL_INC: begin
        upd.len      = act.len - LEN_W'(1);
        len_borrow_d = (act.len == LEN_W'(0));
      end
      default: ;
    endcase
  end

  // Bank and flag registers; only the bank selected at the edge is written.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      bank_q[0]    <= '0;
      bank_q[1]    <= '0;
      lb_wrap_q    <= 1'b0;
      mb_wrap_q    <= 1'b0;
      len_borrow_q <= 1'b0;
    end else if (i_ros_advance) begin
      bank_q[i_io_mode] <= upd;
      lb_wrap_q         <= lb_wrap_d;
      mb_wrap_q         <= mb_wrap_d;
      len_borrow_q      <= len_borrow_d;
    end
  end

  assign o_u          = sel_byte(i_l_reg, act.lb);
  assign o_v          = sel_byte(i_r_reg, act.mb);
  assign o_lb         = act.lb;
  assign o_mb         = act.mb;
  assign o_len_zero   = (act.len == LEN_W'(0));
  assign o_lb_wrap    = lb_wrap_q;
  assign o_mb_wrap    = mb_wrap_q;
  assign o_len_borrow = len_borrow_q;

endmodule
